pll_reset_sequencer: RTL and testbench

//   Sequences PLL bring-up and SoC reset release. Pulses the PLL RESETB, waits for a

---
 rtl/pll_reset_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Brings up the PLL and releases the SoC reset. The PLL RESETB is pulsed low,
//   LOCK is synchronized and must stay high for a stable window, then the system
//   reset is held for a fixed time before release. A lock loss in RUN re-asserts
//   the system reset. A PLL that fails to lock within the timeout is re-pulsed.
//   Clocked by the board reference clock, never by the PLL output.
// Ports
//   clk            in   reference clock
//   reset          in   async active-high, forces reset values (PLL re-pulsed)
//   pll_locked     in   raw PLL LOCK, asynchronous to clk
//   clear_stats    in   sync pulse, zeroes lock_loss_cnt and retry_cnt
//   pll_resetb     out  PLL RESETB, active-low, low only in PLL_RST
//   sys_rst        out  SoC reset, active-high, low only in RUN
//   ready          out  high only in RUN
//   state          out  0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 HOLD, 4 RUN
//   lock_loss_cnt  out  RUN->WAIT_LOCK transitions, saturating
//   retry_cnt      out  lock-timeout retries, saturating
module pll_reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int PLL_RST_CYCLES  = 16,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int STABLE_CYCLES   = 1024,
  parameter int RST_HOLD_CYCLES = 256,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pll_locked,
  input  logic             clear_stats,
  output logic             pll_resetb,
  output logic             sys_rst,
  output logic             ready,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  // Each timer only has to reach its parameter minus one, so $clog2 bits suffice.
  localparam int RC_W = (PLL_RST_CYCLES  > 1) ? $clog2(PLL_RST_CYCLES)  : 1;
  localparam int TO_W = (LOCK_TIMEOUT    > 1) ? $clog2(LOCK_TIMEOUT)    : 1;
  localparam int SC_W = (STABLE_CYCLES   > 1) ? $clog2(STABLE_CYCLES)   : 1;
  localparam int HC_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;

  localparam logic [RC_W-1:0]  RST_LAST  = RC_W'(PLL_RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [SC_W-1:0]  STAB_LAST = SC_W'(STABLE_CYCLES - 1);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t                 st_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   locked_s;
  logic [RC_W-1:0]        rst_cnt_r;
  logic [TO_W-1:0]        to_cnt_r;
  logic [SC_W-1:0]        stab_cnt_r;
  logic [HC_W-1:0]        hold_cnt_r;
  logic                   timeout_s;
  logic                   loss_s;

  // LOCK synchronizer; the FSM only ever looks at the last stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_r[SYNC_STAGES-1];
  assign state    = st_r;

  // Timeout and lock-loss events, shared by the FSM and the statistics counters.
  always_comb begin
    timeout_s = 1'b0;
    loss_s    = 1'b0;
    if ((st_r == S_WAIT_LOCK) || (st_r == S_STABLE)) begin
      timeout_s = (to_cnt_r == TO_LAST);
    end else begin
      timeout_s = 1'b0;
    end
    if (st_r == S_RUN) begin
      loss_s = ~locked_s;
    end else begin
      loss_s = 1'b0;
    end
  end

  // Sequencer FSM; outputs are updated on the same edge as the state they decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_r       <= S_PLL_RST;
      pll_resetb <= 1'b0;
      sys_rst    <= 1'b1;
      ready      <= 1'b0;
      rst_cnt_r  <= '0;
      to_cnt_r   <= '0;
      stab_cnt_r <= '0;
      hold_cnt_r <= '0;
    end else begin
      case (st_r)
        S_PLL_RST: begin
          if (rst_cnt_r == RST_LAST) begin
            st_r       <= S_WAIT_LOCK;
            pll_resetb <= 1'b1;
            to_cnt_r   <= '0;
          end else begin
            rst_cnt_r <= rst_cnt_r + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          // Timeout wins over any other transition on the same edge.
          if (timeout_s) begin
            st_r       <= S_PLL_RST;
            pll_resetb <= 1'b0;
            rst_cnt_r  <= '0;
          end else begin
            to_cnt_r <= to_cnt_r + 1'b1;
            if (locked_s) begin
              st_r       <= S_STABLE;
              stab_cnt_r <= '0;
            end
          end
        end
        S_STABLE: begin
          if (timeout_s) begin
            st_r       <= S_PLL_RST;
            pll_resetb <= 1'b0;
            rst_cnt_r  <= '0;
          end else begin
            // A glitch sends us back without clearing the timeout, so a
            // chattering LOCK still ends in a retry.
            to_cnt_r <= to_cnt_r + 1'b1;
            if (!locked_s) begin
              st_r <= S_WAIT_LOCK;
            end else if (stab_cnt_r == STAB_LAST) begin
              st_r       <= S_HOLD;
              hold_cnt_r <= '0;
            end else begin
              stab_cnt_r <= stab_cnt_r + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!locked_s) begin
            st_r     <= S_WAIT_LOCK;
            to_cnt_r <= '0;
          end else if (hold_cnt_r == HOLD_LAST) begin
            st_r    <= S_RUN;
            sys_rst <= 1'b0;
            ready   <= 1'b1;
          end else begin
            hold_cnt_r <= hold_cnt_r + 1'b1;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            st_r     <= S_WAIT_LOCK;
            sys_rst  <= 1'b1;
            ready    <= 1'b0;
            to_cnt_r <= '0;
          end
        end
        default: begin
          st_r       <= S_PLL_RST;
          pll_resetb <= 1'b0;
          sys_rst    <= 1'b1;
          ready      <= 1'b0;
          rst_cnt_r  <= '0;
        end
      endcase
    end
  end

  // Saturating statistics; clear_stats beats an increment on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_loss_cnt <= '0;
      retry_cnt     <= '0;
    end else if (clear_stats) begin
      lock_loss_cnt <= '0;
      retry_cnt     <= '0;
    end else begin
      if (loss_s && (lock_loss_cnt != CNT_MAX)) begin
        lock_loss_cnt <= lock_loss_cnt + 1'b1;
      end
      if (timeout_s && (retry_cnt != CNT_MAX)) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Directed scenarios plus randomized LOCK patterns, all compared every cycle
//   against an elapsed-time reference model of the sequencer.
module tb_pll_reset_sequencer;

  localparam int SYNC  = 2;
  localparam int PRST  = 4;
  localparam int TOUT  = 32;
  localparam int STAB  = 8;
  localparam int HOLDC = 4;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          pll_locked;
  logic          clear_stats;
  logic          pll_resetb;
  logic          sys_rst;
  logic          ready;
  logic [2:0]    state;
  logic [CW-1:0] lock_loss_cnt;
  logic [CW-1:0] retry_cnt;

  int n_vec;
  int n_err;

  // Reference model: phase number, edges spent in the phase, edges since the
  // lock wait began, a delay line of sampled LOCK values, and the two counters.
  int m_state;
  int m_elapsed;
  int m_wait;
  int m_loss;
  int m_retry;
  bit m_dly[$];

  int n;
  int lowc;
  int saw_hold;
  int kind;
  int len;
  int per;

  pll_reset_sequencer #(
    .SYNC_STAGES    (SYNC),
    .PLL_RST_CYCLES (PRST),
    .LOCK_TIMEOUT   (TOUT),
    .STABLE_CYCLES  (STAB),
    .RST_HOLD_CYCLES(HOLDC),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_locked   (pll_locked),
    .clear_stats  (clear_stats),
    .pll_resetb   (pll_resetb),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .state        (state),
    .lock_loss_cnt(lock_loss_cnt),
    .retry_cnt    (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state   = 0;
    m_elapsed = 0;
    m_wait    = 0;
    m_loss    = 0;
    m_retry   = 0;
    m_dly.delete();
    for (int i = 0; i < SYNC; i++) m_dly.push_back(1'b0);
  endfunction

  function automatic void model_goto(input int s);
    m_state   = s;
    m_elapsed = 0;
  endfunction

  function automatic void model_step(input bit lk, input bit cs);
    bit ls;
    bit lost;
    bit retried;
    ls = m_dly.pop_front();
    m_dly.push_back(lk);
    lost    = 1'b0;
    retried = 1'b0;
    m_elapsed++;
    if (m_state == 1 || m_state == 2) m_wait++;
    case (m_state)
      0: if (m_elapsed >= PRST) begin model_goto(1); m_wait = 0; end
      1: begin
        if (m_wait >= TOUT) begin model_goto(0); retried = 1'b1; end
        else if (ls) model_goto(2);
      end
      2: begin
        if (m_wait >= TOUT) begin model_goto(0); retried = 1'b1; end
        else if (!ls) model_goto(1);
        else if (m_elapsed >= STAB) model_goto(3);
      end
      3: begin
        if (!ls) begin model_goto(1); m_wait = 0; end
        else if (m_elapsed >= HOLDC) model_goto(4);
      end
      4: if (!ls) begin model_goto(1); m_wait = 0; lost = 1'b1; end
      default: model_goto(0);
    endcase
    if (cs) begin
      m_loss  = 0;
      m_retry = 0;
    end else begin
      if (lost)    m_loss  = (m_loss  + 1 > CMAX) ? CMAX : m_loss  + 1;
      if (retried) m_retry = (m_retry + 1 > CMAX) ? CMAX : m_retry + 1;
    end
  endfunction

  task automatic compare_all();
    chk_eq("state",         state,         m_state);
    chk_eq("pll_resetb",    pll_resetb,    m_state != 0);
    chk_eq("sys_rst",       sys_rst,       m_state != 4);
    chk_eq("ready",         ready,         m_state == 4);
    chk_eq("lock_loss_cnt", lock_loss_cnt, m_loss);
    chk_eq("retry_cnt",     retry_cnt,     m_retry);
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge,
  // compare at the next falling edge.
  task automatic cycle(input bit lk, input bit cs);
    pll_locked  = lk;
    clear_stats = cs;
    @(posedge clk);
    model_step(lk, cs);
    @(negedge clk);
    compare_all();
    clear_stats = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must change before any edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    reset = 1'b0;
  endtask

  task automatic run_to_state(input string tag, input logic [2:0] target, input int budget);
    int k;
    k = 0;
    while (state != target && k < budget) begin
      cycle(1'b1, 1'b0);
      k++;
    end
    n = k;
    chk_eq(tag, state, target);
  endtask

  // Lock drop seen by the FSM two edges later; clear_stats can ride that edge.
  task automatic lock_drop(input bit clr_on_loss);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, clr_on_loss);
  endtask

  function automatic bit rnd_clr();
    return ($urandom_range(0, 15) == 0);
  endfunction

  initial begin
    n_vec       = 0;
    n_err       = 0;
    reset       = 1'b1;
    pll_locked  = 1'b0;
    clear_stats = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    chk_eq("rst_pll_resetb", pll_resetb, 1'b0);
    chk_eq("rst_sys_rst", sys_rst, 1'b1);
    reset = 1'b0;

    // Bring-up latency: LOCK first sampled at edge 5, ready expected at edge 19.
    for (int i = 0; i < PRST; i++) cycle(1'b0, 1'b0);
    chk_eq("t1_wait_lock", state, 3'd1);
    for (int i = 0; i < SYNC + STAB + HOLDC; i++) cycle(1'b1, 1'b0);
    chk_eq("t1_ready_early", ready, 1'b0);
    cycle(1'b1, 1'b0);
    chk_eq("t1_ready", ready, 1'b1);
    chk_eq("t1_sys_rst", sys_rst, 1'b0);

    // One-cycle lock drop in RUN.
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    chk_eq("t2_sys_rst_before", sys_rst, 1'b0);
    cycle(1'b1, 1'b0);
    chk_eq("t2_sys_rst", sys_rst, 1'b1);
    chk_eq("t2_loss_cnt", lock_loss_cnt, 1);
    run_to_state("t2_relock", 3'd4, 100);
    chk_eq("t2_relock_cycles", n, STAB + HOLDC + 1);

    // Lock-loss counter saturation, then clear on the same edge as a loss.
    for (int i = 0; i < 4; i++) begin
      lock_drop(1'b0);
      run_to_state("t5_relock", 3'd4, 100);
    end
    chk_eq("t5_loss_sat", lock_loss_cnt, CMAX);
    lock_drop(1'b1);
    chk_eq("t5_clear_wins", lock_loss_cnt, 0);

    // Reset in HOLD and in RUN with a non-zero counter.
    run_to_state("t6_run_a", 3'd4, 100);
    lock_drop(1'b0);
    run_to_state("t6_hold", 3'd3, 100);
    do_reset();
    chk_eq("t6_hold_state", state, 3'd0);
    run_to_state("t6_run_b", 3'd4, 100);
    lock_drop(1'b0);
    run_to_state("t6_run_c", 3'd4, 100);
    do_reset();
    chk_eq("t6_run_loss", lock_loss_cnt, 0);
    chk_eq("t6_run_ready", ready, 1'b0);

    // LOCK never arrives: three retries, RESETB pulsed each time.
    do_reset();
    lowc = 0;
    for (int i = 0; i < PRST + 3 * (TOUT + PRST); i++) begin
      cycle(1'b0, 1'b0);
      if (pll_resetb == 1'b0) lowc++;
    end
    chk_eq("t3_resetb_low", lowc, 4 * PRST - 1);
    chk_eq("t3_retry", retry_cnt, 3);
    chk_eq("t3_state", state, 3'd1);

    // LOCK chatters with period 10: never stable long enough, one retry.
    do_reset();
    for (int i = 0; i < PRST; i++) cycle(1'b0, 1'b0);
    saw_hold = 0;
    for (int i = 0; i < TOUT; i++) begin
      cycle(((i / 5) % 2) == 0, 1'b0);
      if (state == 3'd3) saw_hold = 1;
    end
    chk_eq("t4_no_hold", saw_hold, 0);
    chk_eq("t4_state", state, 3'd0);
    chk_eq("t4_retry", retry_cnt, 1);

    // Randomized LOCK behaviour.
    for (int s = 0; s < 80; s++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin
          len = $urandom_range(1, 40);
          repeat (len) cycle(1'b1, rnd_clr());
        end
        1: begin
          len = $urandom_range(1, 45);
          repeat (len) cycle(1'b0, rnd_clr());
        end
        2: begin
          per = $urandom_range(1, 7);
          for (int i = 0; i < 24; i++) cycle(((i / per) % 2) == 0, rnd_clr());
        end
        3: cycle(1'b0, rnd_clr());
        default: begin
          if ($urandom_range(0, 3) == 0) do_reset();
          else cycle(1'b1, 1'b0);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
